round_key_store: RTL and testbench
==================================

# round_key_store

Round-key buffer feeding the sigma (key-addition XOR) stage of the Anubis datapath. It captures the 13 round keys produced by the key schedule through a valid/ready load port. It then replays them one per round to the sigma stage's key input, in forward (encrypt) or reverse (decrypt) order. Keys are loaded once per cipher key and can be replayed for any number of blocks.

## Interface
- KEY_W, 128, round-key width; equals the sigma operand width
- NUM_KEYS, 13, number of stored round keys (R+1, R=12 for a 128-bit key)
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- load_start  in  1  pulse: discard stored keys and begin a new load
- load_valid  in  1  load_key is valid this cycle
- load_key  in  KEY_W  round key from the key schedule, delivered in order K0..K12
- load_ready  out  1  store accepts a key this cycle
- keys_ready  out  1  all NUM_KEYS keys are held and a replay may start
- rd_start  in  1  pulse: begin a replay
- rd_dir  in  1  sampled with rd_start: 0 = K0→K12 (encrypt), 1 = K12→K0 (decrypt)
- rd_advance  in  1  consumer has used the current key; step to the next one
- rd_key  out  KEY_W  current round key; this drives sigma in2
- rd_round  out  4  index of the key on rd_key (0..12)
- rd_valid  out  1  rd_key and rd_round are valid
- rd_last  out  1  rd_valid and the current key is the final key of the replay

## Operation
- Storage: NUM_KEYS x KEY_W register array. Write pointer wptr is 4 bits. Read index ridx is 4 bits. Direction flag dir.
- The FSM has four states: EMPTY, LOADING, READY, SERVING.
- EMPTY (after reset):
  - load_start → LOADING, wptr=0.
  - rd_start is ignored.
- LOADING:
  - load_ready=1.
  - Each cycle with load_valid=1 writes load_key into mem[wptr] and increments wptr.
  - The write with wptr=NUM_KEYS-1 → READY.
  - load_start here restarts the load: wptr=0, state stays LOADING, and any load_valid in that cycle is dropped.
- READY:
  - keys_ready=1.
  - rd_start → SERVING. On that edge: dir=rd_dir; ridx=0 if rd_dir=0, else NUM_KEYS-1; rd_key is loaded from mem[ridx].
  - load_start → LOADING with wptr=0 and keys_ready cleared. It takes priority over rd_start in the same cycle.
- SERVING:
  - rd_valid=1 and keys_ready=1.
  - On rd_advance when rd_last=0: ridx steps +1 if dir=0 or −1 if dir=1, and rd_key/rd_round update to the new key.
  - On rd_advance when rd_last=1 → READY, rd_valid=0.
  - load_start and rd_start are ignored. A replay cannot be corrupted mid-block.
- Output definitions:
  - rd_last is high when rd_valid=1 and ridx equals the terminal index: NUM_KEYS-1 if dir=0, 0 if dir=1.
  - load_ready=1 only in LOADING.
  - rd_valid=1 only in SERVING.
  - keys_ready=1 in READY and SERVING.
- No arithmetic wraps. ridx never leaves 0..NUM_KEYS-1, and wptr never exceeds NUM_KEYS-1 while writing.

## Timing
- Reset values, applied asynchronously when rst_n is low:
  - state=EMPTY, wptr=0, ridx=0, dir=0.
  - load_ready=0, keys_ready=0, rd_valid=0, rd_last=0, rd_key=0, rd_round=0.
  - Memory contents are not reset.
- rd_key, rd_round and rd_valid are registered outputs. rd_last is decoded from registered state only.
- Load phase:
  - Full load with load_valid held high: 13 cycles after the first accepted key.
  - keys_ready rises on the edge that writes K12.
- Replay latency:
  - rd_start sampled at edge N gives rd_valid=1 with the first key after edge N.
  - Each rd_advance sampled at edge M presents the next key after edge M.
  - With rd_advance held high, a replay delivers one key per cycle (13 cycles).
  - rd_start may be asserted in the cycle after rd_valid falls, so back-to-back blocks lose one idle cycle.
- Reset during LOADING or SERVING aborts immediately to EMPTY. A new full load is required afterwards.

## Test plan
- Reset then load: assert rst_n low, then load K_i = {16{8'h10+i}} for i=0..12 with load_valid held high. Required: load_ready high for exactly 13 cycles, then keys_ready=1 and load_ready=0.
- Encrypt replay: from READY, rd_start with rd_dir=0 and rd_advance held high. Required: rd_round 0..12 on consecutive cycles, rd_key matching K_i, rd_last only at round 12, then rd_valid=0 and state READY.
- Decrypt replay with stalls: rd_start with rd_dir=1, and rd_advance toggling 1,0,1,0. Required: rd_round 12,12,11,11,10…; each key held while rd_advance=0; rd_last only at round 0.
- Load interruptions:
  - Gaps: drive load_valid 1,0,0,1… across the load. Required: only valid beats are written.
  - Restart: pulse load_start after 5 keys. Required: wptr restarts, keys_ready stays 0 until 13 fresh keys are written, and the replay shows only the new keys.
- Illegal requests:
  - rd_start in EMPTY or LOADING: required no rd_valid.
  - load_start or rd_start during SERVING: required the replay continues unchanged.
  - load_start and rd_start together in READY: required entry to LOADING.
- Async reset mid-replay: drop rst_n at round 6. Required: all outputs go to 0 without waiting for a clk edge. After release the block is in EMPTY and rd_start is ignored.

Source files
------------

// File: rtl/round_key_store_if.sv
// rtl/round_key_store_if.sv - load and replay port bundle for the round-key store
interface round_key_store_if #(
    parameter int KEY_W = 128
);
    logic             load_start;
    logic             load_valid;
    logic [KEY_W-1:0] load_key;
    logic             load_ready;
    logic             keys_ready;
    logic             rd_start;
    logic             rd_dir;
    logic             rd_advance;
    logic [KEY_W-1:0] rd_key;
    logic [3:0]       rd_round;
    logic             rd_valid;
    logic             rd_last;

    modport master (
        output load_start, load_valid, load_key, rd_start, rd_dir, rd_advance,
        input  load_ready, keys_ready, rd_key, rd_round, rd_valid, rd_last
    );

    modport slave (
        input  load_start, load_valid, load_key, rd_start, rd_dir, rd_advance,
        output load_ready, keys_ready, rd_key, rd_round, rd_valid, rd_last
    );
endinterface

// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - round-key buffer replaying keys to the sigma stage
module round_key_store #(
    parameter int KEY_W    = 128,
    parameter int NUM_KEYS = 13
) (
    input logic              clk,
    input logic              rst_n,
    round_key_store_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, LOADING, READY, SERVING} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);

    state_t           state;
    logic [KEY_W-1:0] mem [NUM_KEYS];
    logic [3:0]       wptr;
    logic [3:0]       ridx;
    logic             dir;
    logic             load_ready_q;
    logic             keys_ready_q;
    logic             rd_valid_q;
    logic [KEY_W-1:0] rd_key_q;

    logic [3:0] start_idx;
    logic [3:0] next_idx;
    logic [3:0] term_idx;
    logic       is_last;
    logic       mem_we;

    assign start_idx = bus.rd_dir ? LAST_IDX : 4'd0;
    // next_idx is only consumed when the current key is not terminal, so it never wraps
    assign next_idx  = dir ? (ridx - 4'd1) : (ridx + 4'd1);
    assign term_idx  = dir ? 4'd0 : LAST_IDX;
    assign is_last   = rd_valid_q && (ridx == term_idx);
    // a restart pulse drops any beat presented in the same cycle
    assign mem_we    = (state == LOADING) && bus.load_valid && !bus.load_start;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr] <= bus.load_key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            wptr         <= 4'd0;
            ridx         <= 4'd0;
            dir          <= 1'b0;
            load_ready_q <= 1'b0;
            keys_ready_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_key_q     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (bus.load_start) begin
                        state        <= LOADING;
                        wptr         <= 4'd0;
                        load_ready_q <= 1'b1;
                    end
                end
                LOADING: begin
                    if (bus.load_start) begin
                        wptr <= 4'd0;
                    end else if (bus.load_valid) begin
                        if (wptr == LAST_IDX) begin
                            state        <= READY;
                            load_ready_q <= 1'b0;
                            keys_ready_q <= 1'b1;
                        end else begin
                            wptr <= wptr + 4'd1;
                        end
                    end
                end
                READY: begin
                    if (bus.load_start) begin
                        state        <= LOADING;
                        wptr         <= 4'd0;
                        load_ready_q <= 1'b1;
                        keys_ready_q <= 1'b0;
                    end else if (bus.rd_start) begin
                        state      <= SERVING;
                        dir        <= bus.rd_dir;
                        ridx       <= start_idx;
                        rd_key_q   <= mem[start_idx];
                        rd_valid_q <= 1'b1;
                    end
                end
                SERVING: begin
                    if (bus.rd_advance) begin
                        if (is_last) begin
                            state      <= READY;
                            rd_valid_q <= 1'b0;
                        end else begin
                            ridx     <= next_idx;
                            rd_key_q <= mem[next_idx];
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.keys_ready = keys_ready_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_key     = rd_key_q;
    assign bus.rd_round   = ridx;
    assign bus.rd_last    = is_last;
endmodule

// File: tb/tb_round_key_store.sv
// tb/tb_round_key_store.sv - directed self-checking bench for round_key_store
module tb_round_key_store;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    round_key_store_if #(.KEY_W(128)) bus ();

    round_key_store #(.KEY_W(128), .NUM_KEYS(13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] kf(input logic [7:0] base, input int i);
        logic [7:0] b;
        b = base + 8'(i);
        return {16{b}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int  hi;
        int  e;
        int  j;
        bit  done;
        bit  adv;
        bit  v;

        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_key   = '0;
        bus.rd_start   = 1'b0;
        bus.rd_dir     = 1'b0;
        bus.rd_advance = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_load_ready", bus.load_ready, 0);
        chk("rst_keys_ready", bus.keys_ready, 0);
        chk("rst_rd_valid",   bus.rd_valid,   0);
        chk("rst_rd_last",    bus.rd_last,    0);
        chk("rst_rd_key",     bus.rd_key,     0);
        chk("rst_rd_round",   bus.rd_round,   0);
        rst_n = 1'b1;

        // rd_start in EMPTY
        bus.rd_start = 1'b1;
        @(negedge clk);
        bus.rd_start = 1'b0;
        chk("empty_rd_valid",   bus.rd_valid,   0);
        chk("empty_keys_ready", bus.keys_ready, 0);

        // full load, valid held high
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        hi = 0;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (bus.load_ready) hi++;
            chk("load_keys_ready_low", bus.keys_ready, 0);
            bus.load_key = kf(8'h10, i);
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        chk("load_ready_cycles", 128'(hi), 13);
        chk("load_done_load_ready", bus.load_ready, 0);
        chk("load_done_keys_ready", bus.keys_ready, 1);

        // encrypt replay, illegal load_start/rd_start at round 5
        bus.rd_start   = 1'b1;
        bus.rd_dir     = 1'b0;
        bus.rd_advance = 1'b1;
        @(negedge clk);
        bus.rd_start = 1'b0;
        for (int r = 0; r < 13; r++) begin
            chk("enc_valid", bus.rd_valid, 1);
            chk("enc_round", bus.rd_round, 128'(r));
            chk("enc_key",   bus.rd_key,   kf(8'h10, r));
            chk("enc_last",  bus.rd_last,  (r == 12) ? 1 : 0);
            bus.load_start = (r == 5);
            bus.rd_start   = (r == 5);
            @(negedge clk);
        end
        bus.load_start = 1'b0;
        bus.rd_start   = 1'b0;
        chk("enc_end_valid",      bus.rd_valid,   0);
        chk("enc_end_keys_ready", bus.keys_ready, 1);
        chk("enc_end_load_ready", bus.load_ready, 0);

        // back-to-back decrypt replay with stalls
        bus.rd_start   = 1'b1;
        bus.rd_dir     = 1'b1;
        bus.rd_advance = 1'b0;
        @(negedge clk);
        bus.rd_start = 1'b0;
        e = 12;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            chk("dec_valid", bus.rd_valid, 1);
            chk("dec_round", bus.rd_round, 128'(e));
            chk("dec_key",   bus.rd_key,   kf(8'h10, e));
            chk("dec_last",  bus.rd_last,  (e == 0) ? 1 : 0);
            adv = (c % 2) == 1;
            bus.rd_advance = adv;
            @(negedge clk);
            if (adv) begin
                if (e == 0) done = 1'b1;
                else e--;
            end
        end
        bus.rd_advance = 1'b0;
        chk("dec_done",      128'(done), 1);
        chk("dec_end_valid", bus.rd_valid, 0);

        // load_start wins over rd_start in READY
        bus.load_start = 1'b1;
        bus.rd_start   = 1'b1;
        bus.rd_dir     = 1'b0;
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.rd_start   = 1'b0;
        chk("both_load_ready", bus.load_ready, 1);
        chk("both_keys_ready", bus.keys_ready, 0);
        chk("both_rd_valid",   bus.rd_valid,   0);

        // five keys, with rd_start attempted during LOADING
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_key   = kf(8'h10, i);
            bus.rd_start   = (i == 2);
            @(negedge clk);
            chk("loading_rd_valid", bus.rd_valid, 0);
        end
        bus.rd_start = 1'b0;

        // restart with a dropped beat, then gapped load of fresh keys
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_key   = {4{32'hdeadbeef}};
        @(negedge clk);
        bus.load_start = 1'b0;
        chk("restart_keys_ready", bus.keys_ready, 0);
        chk("restart_load_ready", bus.load_ready, 1);
        j = 0;
        for (int c = 0; c < 60 && j < 13; c++) begin
            chk("gap_keys_ready", bus.keys_ready, 0);
            v = (c % 3) == 0;
            bus.load_valid = v;
            bus.load_key   = v ? kf(8'ha0, j) : {4{32'hbadc0ffe}};
            @(negedge clk);
            if (v) j++;
        end
        bus.load_valid = 1'b0;
        chk("gap_count",      128'(j), 13);
        chk("gap_keys_ready_done", bus.keys_ready, 1);
        chk("gap_load_ready_done", bus.load_ready, 0);

        // replay shows only the fresh keys
        bus.rd_start   = 1'b1;
        bus.rd_dir     = 1'b0;
        bus.rd_advance = 1'b1;
        @(negedge clk);
        bus.rd_start = 1'b0;
        for (int r = 0; r < 13; r++) begin
            chk("new_round", bus.rd_round, 128'(r));
            chk("new_key",   bus.rd_key,   kf(8'ha0, r));
            chk("new_last",  bus.rd_last,  (r == 12) ? 1 : 0);
            @(negedge clk);
        end
        chk("new_end_valid", bus.rd_valid, 0);

        // async reset at round 6
        bus.rd_start = 1'b1;
        @(negedge clk);
        bus.rd_start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_round", bus.rd_round, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_valid",   bus.rd_valid,   0);
        chk("arst_rd_last",    bus.rd_last,    0);
        chk("arst_rd_key",     bus.rd_key,     0);
        chk("arst_rd_round",   bus.rd_round,   0);
        chk("arst_keys_ready", bus.keys_ready, 0);
        chk("arst_load_ready", bus.load_ready, 0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.rd_advance = 1'b0;
        bus.rd_start   = 1'b1;
        @(negedge clk);
        bus.rd_start = 1'b0;
        @(negedge clk);
        chk("post_rst_rd_valid",   bus.rd_valid,   0);
        chk("post_rst_keys_ready", bus.keys_ready, 0);
        chk("post_rst_load_ready", bus.load_ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
